// File: rtl/fetch_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue_if : imem, redirect/halt and decode handshake bundle          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface fetch_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc, halt,
    output instr_valid,
    input  instr_ready,
    output instr, instr_pc, pc_plus, err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc, halt,
    input  instr_valid,
    output instr_ready,
    input  instr, instr_pc, pc_plus, err
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue : fetch PC owner, single-outstanding imem requester and      |
// |               DEPTH-entry instruction queue feeding decode. Rev 1.0      |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master io_fq
);
  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [ADDR_W-1:0]  c_INC   = ADDR_W'(PC_INC);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic [ADDR_W-1:0]  r_fpc, w_fpc_next, r_addr;
  logic               r_req, r_halted, r_err;
  logic [DATA_W-1:0]  r_qdata [DEPTH];
  logic [ADDR_W-1:0]  r_qpc   [DEPTH];
  logic [c_PTR_W-1:0] r_wptr, r_rptr;
  logic [c_CNT_W-1:0] r_count, w_count_next;
  logic               w_valid, w_push, w_pop, w_halted, w_credit, w_issue, w_misalign;

  assign w_valid    = (r_count != '0);
  assign w_push     = (r_state == S_REQ) & io_fq.imem_ack & ~io_fq.redirect;
  assign w_pop      = w_valid & io_fq.instr_ready & ~io_fq.redirect;
  assign w_halted   = r_halted | io_fq.halt;
  assign w_misalign = ((32'(io_fq.redirect_pc) % PC_INC) != 0);

  // Credit is judged on the post-update count, so the request issued now
  // always has a free slot waiting for it when it returns.
  assign w_count_next = io_fq.redirect ? '0
                      : r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
  assign w_credit     = (w_count_next < c_DEPTH);

  always_comb begin
    w_fpc_next = r_fpc;
    if (io_fq.redirect)
      w_fpc_next = io_fq.redirect_pc;
    else if (w_push)
      w_fpc_next = r_fpc + c_INC;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_fq.redirect) begin
          w_state_next = S_IDLE;
        end else if (w_halted) begin
          w_state_next = S_HALTED;
        end else if (w_credit) begin
          w_state_next = S_REQ;
          w_issue      = 1'b1;
        end
      end
      S_REQ, S_DRAIN: begin
        if (io_fq.imem_ack) begin
          if (io_fq.redirect) begin
            w_state_next = S_IDLE;
          end else if (w_halted) begin
            w_state_next = S_HALTED;
          end else if (w_credit) begin
            w_state_next = S_REQ;
            w_issue      = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (io_fq.redirect) begin
          w_state_next = S_DRAIN;
        end
      end
      S_HALTED: begin
        if (io_fq.redirect)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_fpc    <= RESET_PC;
      r_addr   <= RESET_PC;
      r_req    <= 1'b0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_fpc    <= w_fpc_next;
      r_req    <= (w_state_next == S_REQ) || (w_state_next == S_DRAIN);
      if (w_issue)
        r_addr <= w_fpc_next;
      r_halted <= ~io_fq.redirect & w_halted;
      // Stray acks are only flagged; their data never reaches the queue.
      r_err    <= r_err | (io_fq.imem_ack & ~r_req) | (io_fq.redirect & w_misalign);
      r_count  <= w_count_next;
      if (io_fq.redirect) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push)
          r_wptr <= r_wptr + 1'b1;
        if (w_pop)
          r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qdata[r_wptr] <= io_fq.imem_rdata;
      r_qpc[r_wptr]   <= r_fpc;
    end
  end

  assign io_fq.imem_req    = r_req;
  assign io_fq.imem_addr   = r_addr;
  assign io_fq.err         = r_err;
  assign io_fq.instr_valid = w_valid;
  assign io_fq.instr       = w_valid ? r_qdata[r_rptr] : '0;
  assign io_fq.instr_pc    = w_valid ? r_qpc[r_rptr] : '0;
  assign io_fq.pc_plus     = w_valid ? (r_qpc[r_rptr] + c_INC) : '0;
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_queue : directed and random checks of fetch_queue against a     |
// |                  PC-stream reference model. Rev 1.0                      |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam int PC_INC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fq ();

  fetch_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RESET_PC(16'h0000), .PC_INC(PC_INC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_fq(fq)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  // Reference model: decode must see a contiguous PC stream starting at the
  // reset PC or the latest redirect target, each word equal to 0x1000+pc.
  logic [15:0] exp_pc;
  int          occ;
  bit          stale, exp_err;
  bit          prev_req, prev_ack;
  logic [15:0] prev_addr;
  int          lat, lat_cnt;
  bit          rand_lat, force_ack;
  int          n_acks, n_pops;
  logic [15:0] last_pop_pc, last_pop_plus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic ack, pop, push;
    if (force_ack)                          ack = 1'b1;
    else if (fq.imem_req && lat_cnt >= lat) ack = 1'b1;
    else                                    ack = 1'b0;
    fq.imem_ack   = ack;
    fq.imem_rdata = 16'h1000 + fq.imem_addr;

    if (prev_req && !prev_ack)
      chk("req_hold", {fq.imem_req, fq.imem_addr}, {1'b1, prev_addr});
    chk("valid_occ", fq.instr_valid, (occ != 0));
    chk("err", fq.err, exp_err);
    if (!fq.instr_valid) begin
      chk("idle_head", {fq.instr, fq.instr_pc}, 32'h0);
      chk("idle_plus", fq.pc_plus, 16'h0);
    end
    pop = fq.instr_valid && fq.instr_ready && !fq.redirect;
    if (pop) begin
      chk("pop_pc", fq.instr_pc, exp_pc);
      chk("pop_instr", fq.instr, 16'(16'h1000 + exp_pc));
      chk("pop_plus", fq.pc_plus, 16'(exp_pc + 16'd2));
      last_pop_pc   = fq.instr_pc;
      last_pop_plus = fq.pc_plus;
      n_pops++;
      exp_pc = 16'(exp_pc + 16'd2);
    end
    push = ack && fq.imem_req && !fq.redirect && !stale;
    if (ack && !fq.imem_req)                 exp_err = 1'b1;
    if (fq.redirect && fq.redirect_pc[0])    exp_err = 1'b1;
    if (ack && fq.imem_req)                  n_acks++;
    prev_req  = fq.imem_req;
    prev_ack  = ack;
    prev_addr = fq.imem_addr;
    if (fq.redirect) begin
      occ    = 0;
      exp_pc = fq.redirect_pc;
      stale  = fq.imem_req && !ack;
    end else begin
      occ = occ + int'(push) - int'(pop);
      if (ack) stale = 1'b0;
    end

    @(posedge clk);
    #1;
    fq.imem_ack = 1'b0;
    if (ack || !prev_req) begin
      lat_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else begin
      lat_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fq.imem_ack = 1'b0;
    fq.redirect = 1'b0;
    fq.halt     = 1'b0;
    force_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {fq.imem_req, fq.imem_addr}, 32'h0);
    chk("rst_valid", fq.instr_valid, 1'b0);
    chk("rst_head", {fq.instr, fq.instr_pc}, 32'h0);
    chk("rst_plus", fq.pc_plus, 16'h0);
    chk("rst_err", fq.err, 1'b0);
    rst = 1'b1;
    occ = 0; stale = 0; exp_err = 0; exp_pc = 16'h0000;
    prev_req = 0; prev_ack = 0; lat_cnt = 0; n_acks = 0; n_pops = 0;
  endtask

  task automatic wait_req(input string tag, input logic [15:0] addr);
    int n = 0;
    while (!(fq.imem_req && fq.imem_addr == addr) && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {fq.imem_req, fq.imem_addr}, {1'b1, addr});
  endtask

  task automatic wait_pops(input string tag, input int target);
    int n = 0;
    while (n_pops < target && n < 60) begin
      tick();
      n++;
    end
    chk(tag, n_pops, target);
  endtask

  initial begin
    fq.imem_ack = 0; fq.imem_rdata = '0; fq.redirect = 0; fq.redirect_pc = '0;
    fq.halt = 0; fq.instr_ready = 0;
    lat = 0; rand_lat = 0; force_ack = 0;

    // 1: zero-wait streaming, one instruction per cycle
    do_reset();
    fq.instr_ready = 1; lat = 0;
    tick();
    chk("t1_first_req", {fq.imem_req, fq.imem_addr}, {1'b1, 16'h0000});
    repeat (9) tick();
    chk("t1_rate", n_pops, 8);

    // 2: backpressure fills exactly DEPTH entries
    do_reset();
    fq.instr_ready = 0; lat = 0;
    repeat (12) tick();
    chk("t2_acks", n_acks, 4);
    chk("t2_req_idle", fq.imem_req, 1'b0);
    fq.instr_ready = 1;
    wait_req("t2_resume", 16'h0008);
    wait_pops("t2_pops", 4);
    chk("t2_fourth", last_pop_pc, 16'h0006);

    // 3: redirect while a slow request is outstanding
    do_reset();
    fq.instr_ready = 1; lat = 2;
    wait_req("t3_req6", 16'h0006);
    tick();
    fq.redirect = 1; fq.redirect_pc = 16'h0040;
    tick();
    fq.redirect = 0;
    chk("t3_drain", {fq.imem_req, fq.imem_addr}, {1'b1, 16'h0006});
    chk("t3_empty", fq.instr_valid, 1'b0);
    tick();
    chk("t3_new_req", {fq.imem_req, fq.imem_addr}, {1'b1, 16'h0040});
    wait_pops("t3_pop", n_pops + 1);
    chk("t3_first_pc", last_pop_pc, 16'h0040);

    // 4: halt with a request in flight, then resume via redirect
    do_reset();
    fq.instr_ready = 1; lat = 2;
    wait_req("t4_reqA", 16'h000A);
    fq.halt = 1;
    tick();
    fq.halt = 0;
    repeat (12) tick();
    chk("t4_no_req", fq.imem_req, 1'b0);
    chk("t4_lastpop", last_pop_pc, 16'h000A);
    fq.redirect = 1; fq.redirect_pc = 16'h0020;
    tick();
    fq.redirect = 0;
    wait_req("t4_resume", 16'h0020);

    // 5: PC wrap at the top of the address space
    do_reset();
    fq.instr_ready = 1; lat = 0;
    repeat (3) tick();
    fq.redirect = 1; fq.redirect_pc = 16'hFFFE;
    tick();
    fq.redirect = 0;
    wait_req("t5_req", 16'hFFFE);
    tick();
    chk("t5_wrap_req", {fq.imem_req, fq.imem_addr}, {1'b1, 16'h0000});
    wait_pops("t5_pop", n_pops + 1);
    chk("t5_pc", last_pop_pc, 16'hFFFE);
    chk("t5_plus", last_pop_plus, 16'h0000);
    wait_pops("t5_pop2", n_pops + 1);
    chk("t5_pc2", last_pop_pc, 16'h0000);

    // 6: error sources and stickiness
    do_reset();
    fq.instr_ready = 0; lat = 0;
    force_ack = 1;
    tick();
    force_ack = 0;
    chk("t6_err", fq.err, 1'b1);
    chk("t6_valid", fq.instr_valid, 1'b0);
    repeat (5) tick();
    do_reset();
    fq.instr_ready = 1;
    fq.redirect = 1; fq.redirect_pc = 16'h0003;
    tick();
    fq.redirect = 0;
    chk("t6_err_align", fq.err, 1'b1);
    repeat (10) tick();

    // Random traffic: latency, backpressure, redirects, halts, one mid-run reset
    do_reset();
    rand_lat = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      fq.instr_ready = ($urandom_range(0, 3) != 0);
      fq.redirect    = ($urandom_range(0, 39) == 0);
      fq.redirect_pc = 16'($urandom) & 16'hFFFE;
      fq.halt        = ($urandom_range(0, 99) == 0);
      tick();
    end
    fq.redirect = 0; fq.halt = 0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
